// File: rtl/pll_rst_seq.sv
// PLL reset sequencer on the free-running reference clock: pulses the PLL reset, retries
// on lock timeout, qualifies lock and releases two staged domain reset requests.
module pll_rst_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    output logic       pll_rst_o,
    output logic       rst_req0_o,
    output logic       rst_req1_o,
    output logic       ready_o,
    output logic [7:0] retry_cnt_o,
    output logic       lock_lost_o,
    output logic [2:0] state_o
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                      LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAITLK = 3'd1,
        S_STABLE = 3'd2,
        S_REL0   = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync_q, lock_s_q;
    logic [7:0]      retry_q, retry_d;
    logic            lost_q, lost_d;
    logic            pll_rst_q, pll_rst_d;
    logic            req0_q, req0_d;
    logic            req1_q, req1_d;
    logic            ready_q, ready_d;

    // pll_lock is asynchronous to clk; only the second flop's output is used.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync_q   <= pll_lock_i;
            lock_s_q <= sync_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            retry_q   <= 8'd0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            req0_q    <= 1'b1;
            req1_q    <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            req0_q    <= req0_d;
            req1_q    <= req1_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            S_PLLRST: begin
                if (cnt_q == RST_LAST) state_d = S_WAITLK;
            end
            S_WAITLK: begin
                // A lock seen on the timeout cycle wins; no retry is counted then.
                if (lock_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_PLLRST;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
            S_STABLE: begin
                if (!lock_s_q)                state_d = S_WAITLK;
                else if (cnt_q == STB_LAST)   state_d = S_REL0;
            end
            S_REL0: begin
                if (!lock_s_q) begin
                    state_d = S_WAITLK;
                    lost_d  = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!lock_s_q) begin
                    state_d = S_WAITLK;
                    lost_d  = 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_d = (state_d == S_PLLRST);
        req0_d    = !((state_d == S_REL0) || (state_d == S_RUN));
        req1_d    = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
    end

    assign pll_rst_o   = pll_rst_q;
    assign rst_req0_o  = req0_q;
    assign rst_req1_o  = req1_q;
    assign ready_o     = ready_q;
    assign retry_cnt_o = retry_q;
    assign lock_lost_o = lost_q;
    assign state_o     = state_q;

endmodule
